// File: rtl/reaction_pkg.sv
// Shared definitions for the reaction-timer game: FSM states, LFSR constants
// and the 1 ms tick definition.
package reaction_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_COUNT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    localparam int               LFSR_W      = 10;
    localparam logic [LFSR_W-1:0] LFSR_SEED  = 10'h001;
    localparam int               LFSR_TAP_HI = 9;
    localparam int               LFSR_TAP_LO = 6;

    // One tick strobe per millisecond; delays are expressed in ticks.
    localparam int TICK_PERIOD_US = 1000;

    // x^10 + x^7 + 1, Fibonacci form, shifting left.
    function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] q);
        return {q[LFSR_W-2:0], q[LFSR_TAP_HI] ^ q[LFSR_TAP_LO]};
    endfunction

endpackage

// File: rtl/lfsr10.sv
// 10-bit Fibonacci LFSR with enable; escapes the all-zero lockup state by
// reloading the seed on the next clock regardless of the enable.
module lfsr10
    import reaction_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    output logic [LFSR_W-1:0] q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= LFSR_SEED;
        end else if (q == '0) begin
            q <= LFSR_SEED;
        end else if (en) begin
            q <= lfsr_next(q);
        end
    end

endmodule

// File: rtl/random_delay_timer.sv
// Random-delay stage: captures MIN_DELAY + LFSR on a start_delay rising edge
// and counts it down in ticks. RANDOM_DELAY_FIXED_EN drops the random part.
//
// state    | meaning
// ---------+--------------------------------------------------
// ST_IDLE  | waiting for a start edge
// ST_COUNT | counting captured delay down on tick (busy=1)
// ST_DONE  | delay elapsed, time_out=1 until en_lfsr or start
module random_delay_timer
    import reaction_pkg::*;
#(
    parameter int MIN_DELAY = 1000,
    parameter int DELAY_W   = 11
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               tick,
    input  logic               en_lfsr,
    input  logic               start_delay,
    output logic               time_out,
    output logic               busy,
    output logic [DELAY_W-1:0] delay_ms
);

    state_t              state;
    state_t              state_nxt;
    logic [DELAY_W-1:0]  cnt;
    logic [DELAY_W-1:0]  cnt_nxt;
    logic [DELAY_W-1:0]  delay_nxt;
    logic [DELAY_W-1:0]  capture_val;
    logic [LFSR_W-1:0]   lfsr_q;
    logic                start_q;
    logic                start_edge;

    lfsr10 u_lfsr (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (en_lfsr),
        .q     (lfsr_q)
    );

`ifdef RANDOM_DELAY_FIXED_EN
    logic unused_lfsr;
    assign unused_lfsr = ^lfsr_q;
    assign capture_val = DELAY_W'(MIN_DELAY);
`else
    // lfsr_q is the pre-advance value, so a coincident en_lfsr does not shift it.
    assign capture_val = DELAY_W'(MIN_DELAY) + DELAY_W'(lfsr_q);
`endif

    assign start_edge = start_delay & ~start_q;

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        delay_nxt = delay_ms;
        unique case (state)
            ST_IDLE: begin
                if (start_edge) begin
                    state_nxt = ST_COUNT;
                    cnt_nxt   = capture_val;
                    delay_nxt = capture_val;
                end
            end
            ST_COUNT: begin
                // A start edge restarts the countdown and swallows a coincident tick.
                if (start_edge) begin
                    cnt_nxt   = capture_val;
                    delay_nxt = capture_val;
                end else if (tick) begin
                    if (cnt > DELAY_W'(1)) begin
                        cnt_nxt = cnt - DELAY_W'(1);
                    end else begin
                        state_nxt = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                if (start_edge) begin
                    state_nxt = ST_COUNT;
                    cnt_nxt   = capture_val;
                    delay_nxt = capture_val;
                end else if (en_lfsr) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            delay_ms <= '0;
            start_q  <= 1'b0;
            busy     <= 1'b0;
            time_out <= 1'b0;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            delay_ms <= delay_nxt;
            start_q  <= start_delay;
            busy     <= (state_nxt == ST_COUNT);
            time_out <= (state_nxt == ST_DONE);
        end
    end

endmodule

// File: tb/tb_random_delay_timer.sv
// Self-checking bench for random_delay_timer: directed scenarios plus random
// traffic, checked every cycle against a tick-counting reference model.
module tb_random_delay_timer;

    localparam int MIN_DELAY = 1000;
    localparam int DELAY_W   = 11;
`ifdef RANDOM_DELAY_FIXED_EN
    localparam int EXP_FIRST = 1000;
`else
    localparam int EXP_FIRST = 1008;
`endif

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               tick = 1'b0;
    logic               en_lfsr = 1'b0;
    logic               start_delay = 1'b0;
    logic               time_out;
    logic               busy;
    logic [DELAY_W-1:0] delay_ms;

    int n_checks = 0;
    int n_errors = 0;

    random_delay_timer #(.MIN_DELAY(MIN_DELAY), .DELAY_W(DELAY_W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .tick        (tick),
        .en_lfsr     (en_lfsr),
        .start_delay (start_delay),
        .time_out    (time_out),
        .busy        (busy),
        .delay_ms    (delay_ms)
    );

    always #5 clk = ~clk;

    // Reference model: remembers the captured delay and counts ticks seen since
    // capture; the delay has elapsed once that count reaches the delay.
    int m_lfsr, m_delay, m_ticks;
    bit m_active, m_done, m_prev_start;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_lfsr = 1; m_delay = 0; m_ticks = 0;
            m_active = 0; m_done = 0; m_prev_start = 0;
        end else begin
            if (start_delay && !m_prev_start) begin
`ifdef RANDOM_DELAY_FIXED_EN
                m_delay = MIN_DELAY;
`else
                m_delay = MIN_DELAY + m_lfsr;
`endif
                m_ticks = 0; m_active = 1; m_done = 0;
            end else if (m_active) begin
                if (tick) begin
                    m_ticks = m_ticks + 1;
                    if (m_ticks == m_delay) begin
                        m_active = 0; m_done = 1;
                    end
                end
            end else if (m_done && en_lfsr) begin
                m_done = 0;
            end
            m_prev_start = start_delay;
            if (m_lfsr == 0)
                m_lfsr = 1;
            else if (en_lfsr)
                m_lfsr = ((m_lfsr * 2) % 1024) + (((m_lfsr / 512) ^ (m_lfsr / 64)) % 2);
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        chk("busy",     int'(busy),     int'(m_active));
        chk("time_out", int'(time_out), int'(m_done));
        chk("delay_ms", int'(delay_ms), m_delay);
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            tick = 1'b1; step();
            tick = 1'b0; step();
        end
    endtask

    int d3;

    initial begin
        step(); step();
        chk("reset_busy",  int'(busy),     0);
        chk("reset_to",    int'(time_out), 0);
        chk("reset_delay", int'(delay_ms), 0);
        chk("reset_lfsr",  int'(dut.u_lfsr.q), 1);
        rst_n = 1'b1; step();

        // three LFSR advances from seed -> 0x008
        en_lfsr = 1'b1; step(); step(); step();
        en_lfsr = 1'b0; start_delay = 1'b1; step();
        chk("first_delay", int'(delay_ms), EXP_FIRST);
        chk("first_busy",  int'(busy),     1);
        chk("first_to",    int'(time_out), 0);

        ticks(EXP_FIRST - 1);
        chk("pre_last_tick_to", int'(time_out), 0);
        tick = 1'b1; step();
        chk("last_tick_to",   int'(time_out), 1);
        chk("last_tick_busy", int'(busy),     0);
        tick = 1'b0; step(); step(); step();
        chk("done_hold_to", int'(time_out), 1);

        en_lfsr = 1'b1; step();
        en_lfsr = 1'b0;
        chk("new_round_to",   int'(time_out), 0);
        chk("new_round_busy", int'(busy),     0);

        // restart in COUNT with a coincident tick that must be ignored
        start_delay = 1'b0; step();
        start_delay = 1'b1; step();
        ticks(200);
        start_delay = 1'b0; step();
        start_delay = 1'b1; tick = 1'b1; step();
        tick = 1'b0;
        d3 = m_delay;
        chk("restart_busy", int'(busy), 1);
        chk("restart_delay_range", int'(delay_ms >= DELAY_W'(MIN_DELAY)), 1);
        step();
        ticks(d3 - 1);
        chk("restart_pre_to", int'(time_out), 0);
        tick = 1'b1; step();
        tick = 1'b0;
        chk("restart_to", int'(time_out), 1);
        step();

        // asynchronous reset mid-COUNT
        en_lfsr = 1'b1; step(); step(); en_lfsr = 1'b0;
        start_delay = 1'b0; step();
        start_delay = 1'b1; step();
        ticks(50);
        @(negedge clk); #3;
        rst_n = 1'b0; #1;
        chk("async_busy",  int'(busy),     0);
        chk("async_to",    int'(time_out), 0);
        chk("async_delay", int'(delay_ms), 0);
        chk("async_lfsr",  int'(dut.u_lfsr.q), 1);
        start_delay = 1'b0;
        step(); rst_n = 1'b1; step();
        tick = 1'b1;
        for (int i = 0; i < 2500; i++) step();
        tick = 1'b0;
        chk("post_reset_no_to", int'(time_out), 0);

        // random traffic
        for (int i = 0; i < 40000; i++) begin
            tick    = ($urandom_range(1, 0) == 1);
            en_lfsr = ($urandom_range(7, 0) == 0);
            if ($urandom_range(2999, 0) == 0) start_delay = ~start_delay;
            step();
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
